uart_word_loader: RTL and testbench
===================================

UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 SHALL have parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600, serial bit rate.
REQ-003 SHALL have parameter word_size, default 16, memory word width in bits (multiple of 8).
REQ-004 SHALL have parameter inst_size, default 8192, instruction memory depth in words.
REQ-005 SHALL have parameter timeout_cycles, default clk_freq/100, idle cycles that end a load.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rx, input, 1, UART serial line; idle high.
REQ-009 SHALL have port mem_addr, output, clog2(inst_size), instruction memory write address.
REQ-010 SHALL have port mem_data, output, word_size, word to write.
REQ-011 SHALL have port mem_we, output, 1, one-cycle write strobe.
REQ-012 SHALL have port cpu_run, output, 1, high once loading is complete; holds the CPU in reset while low.
REQ-013 SHALL have port busy, output, 1, high while in LOAD.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-015 SHALL decode 8N1, LSB first, with bit period P = clk_freq/baud_rate (integer division); samples taken at mid-bit.
REQ-016 SHALL reject a start bit that is no longer low at P/2; it returns to idle with no byte.
REQ-017 SHALL discard a byte whose stop bit samples 0, and SHALL pulse frame_err for 1 cycle.
REQ-018 SHALL use FSM states WAIT, LOAD and DONE; reset enters WAIT.
REQ-019 WAIT: the first valid byte moves the FSM to LOAD; that byte is kept as byte 0 of word 0.
REQ-020 SHALL assemble each word little-endian: byte k goes to bits [8k+7:8k]; a word needs word_size/8 bytes.
REQ-021 On word completion, SHALL present mem_data and mem_addr with mem_we=1 for exactly 1 cycle, one cycle after the last byte is accepted; mem_addr then increments.
REQ-022 SHALL reset the timeout counter on every valid byte, and also on every rejected start bit or framing-error byte; the counter counts only in LOAD.
REQ-023 When the timeout counter reaches timeout_cycles in LOAD, SHALL go to DONE; a partial word is first written with missing upper bytes as zero.
REQ-024 After the write to address inst_size-1, SHALL go to DONE on the next cycle; further bytes are not written.
REQ-025 DONE SHALL be terminal until reset; cpu_run=1; received bytes are ignored; mem_we stays 0.
REQ-026 A write and a timeout in the same cycle SHALL perform the write, then go to DONE.
REQ-027 SHALL drive busy=1 exactly in LOAD and cpu_run=1 exactly in DONE.

Reset
REQ-028 Asserting reset at any time, including mid-byte or mid-word, SHALL force WAIT, discard partial data, and clear all counters.
REQ-029 During reset, SHALL hold mem_addr=0, mem_data=0, mem_we=0, cpu_run=0, busy=0, frame_err=0.

Structure
REQ-030 SHALL place FSM state encodings (WAIT/LOAD/DONE) and the P computation helper in the shared reflet package.
REQ-031 SHALL put serial decoding in one sub-module, uart_rx_byte (outputs byte[7:0], valid pulse, err pulse); the top holds assembly, addressing and the FSM.

Verification
REQ-032 The bench SHALL cover these scenarios (defaults, P=104 cycles):
- send 0x34,0x12,0x78,0x56 -> writes 0x1234@0, 0x5678@1; after 10000 idle cycles cpu_run=1.
- send 0xAB, then idle -> after timeout, one write 0x00AB@0, then DONE.
- 0x00 with stop bit 0 -> frame_err pulse; no byte stored; FSM stays WAIT.
- rx low for 30 cycles, then high -> no byte; still WAIT.
- inst_size=4, send 10 bytes -> writes @0..3 only; DONE after 8th byte; bytes 9-10 ignored.
- reset asserted after 1.5 words, then send 0x11,0x22 -> first write 0x2211@0.

Source files
------------

// File: rtl/uart_word_loader_pkg.sv
// rtl/uart_word_loader_pkg.sv - shared FSM encodings and bit-period helper
package uart_word_loader_pkg;

  typedef enum logic [1:0] {ST_WAIT, ST_LOAD, ST_DONE} load_state_t;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  function automatic int calc_bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 serial byte receiver with mid-bit sampling
module uart_rx_byte
  import uart_word_loader_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       reject
);

  localparam int P  = calc_bit_period(clk_freq, baud_rate);
  localparam int CW = $clog2(P + 1);
  localparam logic [CW-1:0] FULL = CW'(P - 1);
  localparam logic [CW-1:0] HALF = CW'(P / 2 - 1);

  rx_state_t       state, state_next;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            valid_next, err_next, reject_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    reject_next = 1'b0;
    case (state)
      RX_IDLE:  if (!rx_s) state_next = RX_START;
      RX_START: if (cnt == HALF) begin
                  if (rx_s) begin
                    state_next  = RX_IDLE;
                    reject_next = 1'b1;
                  end else begin
                    state_next = RX_DATA;
                  end
                end
      RX_DATA:  if (cnt == FULL && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (cnt == FULL) begin
                  if (rx_s) begin
                    valid_next = 1'b1;
                    state_next = RX_IDLE;
                  end else begin
                    err_next   = 1'b1;
                    state_next = RX_BREAK;
                  end
                end
      // a low stop bit must not be mistaken for the next start bit
      RX_BREAK: if (rx_s) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      reject  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      valid   <= valid_next;
      err     <= err_next;
      reject  <= reject_next;
      if (state_next != state || state == RX_IDLE || cnt == FULL) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && cnt == FULL) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign data = shreg;

endmodule

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - loads UART bytes as little-endian words into instruction memory
module uart_word_loader
  import uart_word_loader_pkg::*;
#(
  parameter int clk_freq       = 1000000,
  parameter int baud_rate      = 9600,
  parameter int word_size      = 16,
  parameter int inst_size      = 8192,
  parameter int timeout_cycles = clk_freq / 100
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        rx,
  output logic [((inst_size > 1) ? $clog2(inst_size) : 1)-1:0] mem_addr,
  output logic [word_size-1:0]                        mem_data,
  output logic                                        mem_we,
  output logic                                        cpu_run,
  output logic                                        busy,
  output logic                                        frame_err
);

  localparam int BPW = word_size / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW  = (inst_size > 1) ? $clog2(inst_size) : 1;
  localparam int TW  = $clog2(timeout_cycles + 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(inst_size - 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);
  localparam logic [TW-1:0]  T_LIMIT   = TW'(timeout_cycles);

  load_state_t          state, state_next;
  logic [7:0]           rx_data;
  logic                 rx_valid, rx_err, rx_reject;
  logic [BIW-1:0]       byte_idx;
  logic [word_size-1:0] word_buf, asm_word;
  logic [TW-1:0]        tcnt;
  logic                 finish;
  logic                 accept, word_done, timeout_hit, flush;

  uart_rx_byte #(
    .clk_freq  (clk_freq),
    .baud_rate (baud_rate)
  ) u_rx (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .data   (rx_data),
    .valid  (rx_valid),
    .err    (rx_err),
    .reject (rx_reject)
  );

  // finish marks that the pending write is the last one before DONE
  assign accept      = rx_valid && (state == ST_WAIT || (state == ST_LOAD && !finish));
  assign word_done   = accept && (byte_idx == LAST_BYTE);
  assign timeout_hit = (state == ST_LOAD) && !finish && !mem_we && (tcnt >= T_LIMIT);
  assign flush       = timeout_hit && !accept && (byte_idx != '0);

  always_comb begin
    asm_word = word_buf;
    for (int k = 0; k < BPW; k++) begin
      if (byte_idx == BIW'(k)) asm_word[8*k +: 8] = rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: if (accept) state_next = ST_LOAD;
      ST_LOAD: begin
        if (mem_we && finish) state_next = ST_DONE;
        else if (timeout_hit && !accept && byte_idx == '0) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      word_buf <= '0;
      byte_idx <= '0;
      tcnt     <= '0;
      finish   <= 1'b0;
    end else begin
      mem_we <= word_done || flush;
      if (word_done) begin
        mem_data <= asm_word;
        word_buf <= '0;
        byte_idx <= '0;
      end else if (accept) begin
        word_buf <= asm_word;
        byte_idx <= byte_idx + 1'b1;
      end else if (flush) begin
        mem_data <= word_buf;
        word_buf <= '0;
        byte_idx <= '0;
      end
      if ((word_done || flush) && (mem_addr == LAST_ADDR || timeout_hit)) finish <= 1'b1;
      if (mem_we && mem_addr != LAST_ADDR) mem_addr <= mem_addr + 1'b1;
      if (state != ST_LOAD || rx_valid || rx_err || rx_reject) tcnt <= '0;
      else if (tcnt < T_LIMIT) tcnt <= tcnt + 1'b1;
    end
  end

  assign busy      = (state == ST_LOAD);
  assign cpu_run   = (state == ST_DONE);
  assign frame_err = rx_err;

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - self-checking bench for uart_word_loader
module tb_uart_word_loader;

  localparam int P = 1000000 / 9600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_a = 1'b1, rx_b = 1'b1;
  logic [12:0] addr_a;
  logic [1:0]  addr_b;
  logic [15:0] data_a, data_b;
  logic        we_a, we_b, run_a, run_b, busy_a, busy_b, ferr_a, ferr_b;

  int errors = 0, checks = 0;
  int obs_a_addr[$], obs_a_data[$], obs_b_addr[$], obs_b_data[$];
  int exp_addr[$], exp_data[$];
  int sent_q[$];
  int frame_a = 0, we_long = 0, we_done = 0;
  logic we_a_prev = 1'b0, we_b_prev = 1'b0;

  always #5 clk = ~clk;

  uart_word_loader dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .mem_addr(addr_a), .mem_data(data_a),
    .mem_we(we_a), .cpu_run(run_a), .busy(busy_a), .frame_err(ferr_a)
  );

  uart_word_loader #(.inst_size(4)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .mem_addr(addr_b), .mem_data(data_b),
    .mem_we(we_b), .cpu_run(run_b), .busy(busy_b), .frame_err(ferr_b)
  );

  always @(negedge clk) begin
    if (we_a) begin
      obs_a_addr.push_back(int'(addr_a));
      obs_a_data.push_back(int'(data_a));
      if (run_a) we_done <= we_done + 1;
    end
    if (we_b) begin
      obs_b_addr.push_back(int'(addr_b));
      obs_b_data.push_back(int'(data_b));
      if (run_b) we_done <= we_done + 1;
    end
    if ((we_a && we_a_prev) || (we_b && we_b_prev)) we_long <= we_long + 1;
    if (ferr_a) frame_a <= frame_a + 1;
    we_a_prev <= we_a;
    we_b_prev <= we_b;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
    set_rx(sel, 1'b0);
    idle(P);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      idle(P);
    end
    set_rx(sel, stop);
    idle(P);
    set_rx(sel, 1'b1);
    if (stop) sent_q.push_back(int'(b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    idle(2);
    obs_a_addr.delete(); obs_a_data.delete();
    obs_b_addr.delete(); obs_b_data.delete();
    sent_q.delete();
    reset = 1'b0;
    idle(2);
  endtask

  // Little-endian pairing of every accepted byte; an odd tail byte becomes a zero-padded word.
  task automatic build_expect(input int depth);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < sent_q.size(); i += 2) begin
      int w;
      w = sent_q[i] + ((i + 1 < sent_q.size()) ? sent_q[i+1] * 256 : 0);
      if (exp_addr.size() < depth) begin
        exp_addr.push_back(i / 2);
        exp_data.push_back(w);
      end
    end
  endtask

  task automatic compare_writes(input int sel, input string tag);
    int n;
    n = (sel == 0) ? obs_a_addr.size() : obs_b_addr.size();
    check({tag, " write count"}, n, exp_addr.size());
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      check({tag, " addr"}, (sel == 0) ? obs_a_addr[i] : obs_b_addr[i], exp_addr[i]);
      check({tag, " data"}, (sel == 0) ? obs_a_data[i] : obs_b_data[i], exp_data[i]);
    end
  endtask

  task automatic wait_run(input int sel, input int limit, input string tag);
    int n = 0;
    while (((sel == 0) ? run_a : run_b) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'((sel == 0) ? run_a : run_b), 1);
  endtask

  initial begin
    int f0, nb;

    // reset values while reset is held
    idle(3);
    check("reset mem_addr", int'(addr_a), 0);
    check("reset mem_data", int'(data_a), 0);
    check("reset mem_we", int'(we_a), 0);
    check("reset cpu_run", int'(run_a), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset frame_err", int'(ferr_a), 0);

    // two full words, then timeout
    do_reset();
    send_byte(0, 8'h34, 1'b1);
    check("s1 busy after first byte", int'(busy_a), 1);
    send_byte(0, 8'h12, 1'b1);
    send_byte(0, 8'h78, 1'b1);
    send_byte(0, 8'h56, 1'b1);
    idle(20);
    build_expect(8192);
    compare_writes(0, "s1");
    idle(9000);
    check("s1 cpu_run before timeout", int'(run_a), 0);
    wait_run(0, 2000, "s1 cpu_run after timeout");
    check("s1 busy in done", int'(busy_a), 0);

    // single byte flushed as a partial word
    do_reset();
    send_byte(0, 8'hAB, 1'b1);
    idle(20);
    check("s2 no early write", obs_a_addr.size(), 0);
    wait_run(0, 11000, "s2 cpu_run");
    idle(5);
    build_expect(8192);
    compare_writes(0, "s2");

    // framing error
    do_reset();
    f0 = frame_a;
    send_byte(0, 8'h00, 1'b0);
    idle(300);
    check("s3 frame_err pulses", frame_a - f0, 1);
    check("s3 no write", obs_a_addr.size(), 0);
    check("s3 stays wait", int'(busy_a), 0);

    // runt start bit
    rx_a = 1'b0;
    idle(30);
    rx_a = 1'b1;
    idle(200);
    check("s4 no write", obs_a_addr.size(), 0);
    check("s4 stays wait", int'(busy_a), 0);
    check("s4 no frame_err", frame_a - f0, 1);

    // reset mid-word and mid-byte
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    send_byte(0, 8'hCC, 1'b1);
    rx_a = 1'b0;
    idle(300);
    do_reset();
    check("s6 busy after reset", int'(busy_a), 0);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    idle(20);
    build_expect(8192);
    compare_writes(0, "s6");

    // random byte stream with a random tail
    do_reset();
    nb = $urandom_range(1, 7);
    for (int i = 0; i < nb; i++) send_byte(0, 8'($urandom), 1'b1);
    wait_run(0, 12000, "rand cpu_run");
    idle(5);
    build_expect(8192);
    compare_writes(0, "rand");

    // memory-full stop on the 4-deep instance
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(1, 8'($urandom), 1'b1);
    idle(10);
    check("s5 cpu_run after 8th byte", int'(run_b), 1);
    send_byte(1, 8'h5A, 1'b1);
    send_byte(1, 8'hA5, 1'b1);
    idle(20);
    build_expect(4);
    compare_writes(1, "s5");
    check("s5 busy in done", int'(busy_b), 0);

    check("mem_we single-cycle", we_long, 0);
    check("mem_we quiet in done", we_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
